// File: rtl/ssemi_cic_interpolator.sv
// CIC interpolator: low-rate comb chain, zero-stuffing by R, high-rate integrator chain.
// One input sample produces R output samples through a valid/ready handshake on each side.
module ssemi_cic_interpolator #(
  parameter int CIC_STAGES         = 4,
  parameter int DIFFERENTIAL_DELAY = 1,
  parameter int INTERP_FACTOR      = 8,
  parameter int INPUT_DATA_WIDTH   = 16,
  parameter int OUTPUT_DATA_WIDTH  = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]  i_data,
  output logic [OUTPUT_DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic [5:0]                   o_phase,
  output logic [3:0]                   o_status
);

  localparam int N = CIC_STAGES;
  localparam int M = DIFFERENTIAL_DELAY;
  localparam int W = OUTPUT_DATA_WIDTH;
  localparam logic [5:0] LAST_PHASE = 6'(INTERP_FACTOR - 1);

  if (CIC_STAGES < 1 || CIC_STAGES > 8) begin : g_err_stages
    $error("CIC_STAGES must be in 1..8");
  end
  if (DIFFERENTIAL_DELAY < 1 || DIFFERENTIAL_DELAY > 2) begin : g_err_delay
    $error("DIFFERENTIAL_DELAY must be in 1..2");
  end
  if (INTERP_FACTOR < 2 || INTERP_FACTOR > 64) begin : g_err_interp
    $error("INTERP_FACTOR must be in 2..64");
  end
  if (INPUT_DATA_WIDTH < 8 || INPUT_DATA_WIDTH > 24) begin : g_err_in_width
    $error("INPUT_DATA_WIDTH must be in 8..24");
  end
  if (OUTPUT_DATA_WIDTH < INPUT_DATA_WIDTH || OUTPUT_DATA_WIDTH > 48) begin : g_err_out_width
    $error("OUTPUT_DATA_WIDTH must be in INPUT_DATA_WIDTH..48");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic signed [W-1:0] integ_r     [N];
  logic signed [W-1:0] integ_nxt_s [N];
  logic signed [W-1:0] dly_r       [N][M];
  logic signed [W-1:0] comb_in_s   [N];
  logic signed [W-1:0] cmb_s;
  logic signed [W-1:0] cmb_out_r;
  logic signed [W-1:0] step_x_s;
  logic [5:0]          phase_r;
  logic                accept_r;
  logic                in_hs_s;
  logic                out_hs_s;
  logic                int_step_s;
  logic                last_s;
  logic                emit_s;

  assign emit_s     = (state_r == EMIT);
  assign last_s     = (phase_r == LAST_PHASE);
  assign o_ready    = i_enable && (state_r == IDLE);
  assign in_hs_s    = i_valid && o_ready;
  assign out_hs_s   = emit_s && i_ready;
  assign int_step_s = (state_r == STEP) || (out_hs_s && !last_s);

  // Next-state decode; a low enable overrides any burst in progress
  always_comb begin
    state_nxt_s = state_r;
    if (!i_enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = in_hs_s ? STEP : IDLE;
        STEP:    state_nxt_s = EMIT;
        EMIT:    state_nxt_s = (out_hs_s && last_s) ? IDLE : EMIT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Comb chain on the incoming sample and integrator chain update (Ik' = Ik + I(k-1)')
  always_comb begin : datapath_comb
    logic signed [W-1:0] acc_v;
    acc_v = W'($signed(i_data));
    for (int k = 0; k < N; k++) begin
      comb_in_s[k] = acc_v;
      acc_v        = acc_v - dly_r[k][M-1];
    end
    cmb_s = acc_v;
    if (state_r == STEP) begin
      step_x_s = cmb_out_r;
    end else begin
      step_x_s = {W{1'b0}};
    end
    acc_v = step_x_s;
    for (int k = 0; k < N; k++) begin
      acc_v          = acc_v + integ_r[k];
      integ_nxt_s[k] = acc_v;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Filter state, phase counter and input-accept pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= {W{1'b0}};
        for (int j = 0; j < M; j++) dly_r[k][j] <= {W{1'b0}};
      end
      cmb_out_r <= {W{1'b0}};
      phase_r   <= 6'd0;
      accept_r  <= 1'b0;
    end else if (!i_enable) begin
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= {W{1'b0}};
        for (int j = 0; j < M; j++) dly_r[k][j] <= {W{1'b0}};
      end
      cmb_out_r <= {W{1'b0}};
      phase_r   <= 6'd0;
      accept_r  <= 1'b0;
    end else begin
      if (in_hs_s) begin
        for (int k = 0; k < N; k++) begin
          dly_r[k][0] <= comb_in_s[k];
          for (int j = 1; j < M; j++) dly_r[k][j] <= dly_r[k][j-1];
        end
        cmb_out_r <= cmb_s;
      end
      if (int_step_s) begin
        for (int k = 0; k < N; k++) integ_r[k] <= integ_nxt_s[k];
      end
      if (state_r == STEP) begin
        phase_r <= 6'd0;
      end else if (out_hs_s && !last_s) begin
        phase_r <= phase_r + 6'd1;
      end
      accept_r <= in_hs_s;
    end
  end

  assign o_data   = integ_r[N-1];
  assign o_valid  = i_enable && emit_s;
  assign o_busy   = (state_r != IDLE);
  assign o_phase  = phase_r;
  assign o_status = {o_busy, emit_s, emit_s && last_s, accept_r};

endmodule

// File: tb/tb_ssemi_cic_interpolator.sv
// Bench for ssemi_cic_interpolator: directed vector table, corner sequences, and
// randomized bursts checked against an impulse-response (convolution) reference model.
module tb_ssemi_cic_interpolator;

  logic clk;
  logic rst;
  logic [2:0] en, vld, rdy;
  logic [15:0] din [3];
  logic [31:0] dout [3];
  logic [2:0] ov, ordy, obusy;
  logic [5:0] oph [3];
  logic [3:0] ost [3];

  int n_cmp, n_fail;
  int pr [3];
  longint h [3][64];
  int hlen [3];
  longint u [3][1024];
  int ucnt [3];
  int ocnt [3];

  typedef struct {
    int inst;
    logic signed [15:0] x;
    logic [0:3][31:0] e;
  } vec_t;
  vec_t tab [5];

  ssemi_cic_interpolator #(.CIC_STAGES(1), .DIFFERENTIAL_DELAY(1), .INTERP_FACTOR(4),
    .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(32)) u_n1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en[0]), .i_valid(vld[0]), .o_ready(ordy[0]),
    .i_data(din[0]), .o_data(dout[0]), .o_valid(ov[0]), .i_ready(rdy[0]),
    .o_busy(obusy[0]), .o_phase(oph[0]), .o_status(ost[0]));

  ssemi_cic_interpolator #(.CIC_STAGES(2), .DIFFERENTIAL_DELAY(1), .INTERP_FACTOR(4),
    .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(32)) u_n2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en[1]), .i_valid(vld[1]), .o_ready(ordy[1]),
    .i_data(din[1]), .o_data(dout[1]), .o_valid(ov[1]), .i_ready(rdy[1]),
    .o_busy(obusy[1]), .o_phase(oph[1]), .o_status(ost[1]));

  ssemi_cic_interpolator #(.CIC_STAGES(3), .DIFFERENTIAL_DELAY(2), .INTERP_FACTOR(5),
    .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(32)) u_n3 (
    .i_clk(clk), .i_rst(rst), .i_enable(en[2]), .i_valid(vld[2]), .o_ready(ordy[2]),
    .i_data(din[2]), .o_data(dout[2]), .o_valid(ov[2]), .i_ready(rdy[2]),
    .o_busy(obusy[2]), .o_phase(oph[2]), .o_status(ost[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Impulse response: N-fold convolution of a length R*M boxcar
  task automatic build_h(input int idx, input int n, input int m, input int r);
    longint tmp [64];
    h[idx][0] = 1;
    hlen[idx] = 1;
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < hlen[idx] + r * m - 1; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < r * m; j++)
          if (i - j >= 0 && i - j < hlen[idx]) tmp[i] += h[idx][i-j];
      end
      hlen[idx] = hlen[idx] + r * m - 1;
      for (int i = 0; i < hlen[idx]; i++) h[idx][i] = tmp[i];
    end
  endtask

  task automatic model_clear(input int idx);
    ucnt[idx] = 0;
    ocnt[idx] = 0;
  endtask

  task automatic model_push(input int idx, input logic signed [15:0] x);
    u[idx][ucnt[idx]] = longint'(x);
    ucnt[idx]++;
    for (int i = 1; i < pr[idx]; i++) begin
      u[idx][ucnt[idx]] = 0;
      ucnt[idx]++;
    end
  endtask

  function automatic logic [31:0] model_y(input int idx, input int n);
    longint s = 0;
    for (int k = 0; k < hlen[idx]; k++)
      if (n - k >= 0) s += h[idx][k] * u[idx][n-k];
    return s[31:0];
  endfunction

  task automatic wait_ready(input int idx);
    int g = 0;
    while (ordy[idx] !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", {31'd0, ordy[idx]}, 32'd1);
  endtask

  task automatic burst(input int idx, input logic signed [15:0] x, input bit use_tab,
                       input logic [0:3][31:0] tab_e, input bit rnd_rdy,
                       input int stall_ph, input int stall_len, input bit hold_vld);
    int got = 0;
    int stalled = 0;
    int guard = 0;
    logic [31:0] expv;
    @(negedge clk);
    wait_ready(idx);
    vld[idx] = 1'b1;
    din[idx] = x;
    model_push(idx, x);
    @(negedge clk);
    chk("accept_status", {28'd0, ost[idx]}, 32'h9);
    if (hold_vld) begin
      chk("ready_low_step", {31'd0, ordy[idx]}, 32'd0);
      din[idx] = 16'($urandom);
    end else begin
      vld[idx] = 1'b0;
    end
    while (got < pr[idx] && guard < 300) begin
      @(negedge clk);
      guard++;
      if (hold_vld) begin
        chk("ready_low_emit", {31'd0, ordy[idx]}, 32'd0);
        din[idx] = 16'($urandom);
      end
      if (ov[idx] !== 1'b1) begin
        chk("valid_in_burst", {31'd0, ov[idx]}, 32'd1);
        guard = 300;
      end else begin
        expv = use_tab ? tab_e[got] : model_y(idx, ocnt[idx]);
        chk("out_data", dout[idx], expv);
        chk("out_phase", {26'd0, oph[idx]}, 32'(got));
        chk("out_status", {28'd0, ost[idx]}, {28'd0, 1'b1, 1'b1, got == pr[idx] - 1, 1'b0});
        if (got == stall_ph && stalled < stall_len) begin
          rdy[idx] = 1'b0;
          stalled++;
        end else begin
          rdy[idx] = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rdy[idx]) begin
          got++;
          ocnt[idx]++;
          if (got == pr[idx]) vld[idx] = 1'b0;
        end
      end
    end
    if (got != pr[idx]) chk("burst_count", 32'(got), 32'(pr[idx]));
  endtask

  task automatic apply_row(input int i);
    burst(tab[i].inst, tab[i].x, 1'b1, tab[i].e, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic clear_inst(input int idx);
    @(negedge clk);
    en[idx] = 1'b0;
    #1;
    chk("en_low_ready", {31'd0, ordy[idx]}, 32'd0);
    chk("en_low_valid", {31'd0, ov[idx]}, 32'd0);
    @(negedge clk);
    chk("clr_valid", {31'd0, ov[idx]}, 32'd0);
    chk("clr_busy", {31'd0, obusy[idx]}, 32'd0);
    chk("clr_phase", {26'd0, oph[idx]}, 32'd0);
    chk("clr_data", dout[idx], 32'd0);
    en[idx] = 1'b1;
    model_clear(idx);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    en = 3'b111;
    vld = 3'b000;
    rdy = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 16'd0;
    pr[0] = 4; pr[1] = 4; pr[2] = 5;
    build_h(0, 1, 1, 4);
    build_h(1, 2, 1, 4);
    build_h(2, 3, 2, 5);
    for (int i = 0; i < 3; i++) model_clear(i);
    tab[0] = '{0, 16'sd1, {32'd1, 32'd1, 32'd1, 32'd1}};
    tab[1] = '{0, 16'sd0, {32'd0, 32'd0, 32'd0, 32'd0}};
    tab[2] = '{1, 16'sd1, {32'd1, 32'd2, 32'd3, 32'd4}};
    tab[3] = '{1, 16'sd1, {32'd4, 32'd4, 32'd4, 32'd4}};
    tab[4] = '{1, 16'sd1, {32'd4, 32'd4, 32'd4, 32'd4}};

    // reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", dout[i], 32'd0);
      chk("rst_valid", {31'd0, ov[i]}, 32'd0);
      chk("rst_busy", {31'd0, obusy[i]}, 32'd0);
      chk("rst_phase", {26'd0, oph[i]}, 32'd0);
      chk("rst_status", {28'd0, ost[i]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {29'd0, ordy}, 32'd7);

    // directed vector table
    for (int i = 0; i < 5; i++) apply_row(i);

    // downstream stall at phase 2
    clear_inst(1);
    burst(1, 16'sd100, 1'b0, '0, 1'b0, 2, 3, 1'b0);
    // valid held through the burst
    burst(1, -16'sd7, 1'b0, '0, 1'b0, -1, 0, 1'b1);
    burst(1, 16'sd3, 1'b0, '0, 1'b0, -1, 0, 1'b0);

    // reset pulse at phase 1, then replay the N=2 sequence
    clear_inst(1);
    @(negedge clk);
    wait_ready(1);
    vld[1] = 1'b1;
    din[1] = 16'sd1;
    rdy[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_phase", {26'd0, oph[1]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_data", dout[1], 32'd0);
    chk("midrst_valid", {31'd0, ov[1]}, 32'd0);
    chk("midrst_busy", {31'd0, obusy[1]}, 32'd0);
    chk("midrst_phase", {26'd0, oph[1]}, 32'd0);
    chk("midrst_status", {28'd0, ost[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ordy[1]}, 32'd1);
    for (int i = 0; i < 3; i++) model_clear(i);
    for (int i = 2; i < 5; i++) apply_row(i);

    // enable low for one cycle mid-burst on N=1
    @(negedge clk);
    wait_ready(0);
    vld[0] = 1'b1;
    din[0] = 16'sd5;
    rdy[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    #1;
    chk("en_mid_valid", {31'd0, ov[0]}, 32'd0);
    chk("en_mid_ready", {31'd0, ordy[0]}, 32'd0);
    @(negedge clk);
    chk("en_clr_valid", {31'd0, ov[0]}, 32'd0);
    chk("en_clr_busy", {31'd0, obusy[0]}, 32'd0);
    chk("en_clr_phase", {26'd0, oph[0]}, 32'd0);
    chk("en_clr_data", dout[0], 32'd0);
    en[0] = 1'b1;
    model_clear(0);
    apply_row(0);

    // randomized bursts against the convolution model
    for (int idx = 0; idx < 3; idx++) begin
      clear_inst(idx);
      for (int s = 0; s < 25; s++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        burst(idx, 16'($urandom), 1'b0, '0, 1'b1, -1, 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
